// File: rtl/nand_updown_counter.sv
// rtl/nand_updown_counter.sv - up/down counter with load, enable and optional saturation, NAND2-only next state
module nand_updown_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  // Every combinational primitive below reduces to the single nand2 gate.
  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction

  function automatic logic inv1(input logic a);
    return nand2(a, a);
  endfunction

  function automatic logic and2(input logic a, input logic b);
    return inv1(nand2(a, b));
  endfunction

  function automatic logic xor2(input logic a, input logic b);
    logic n;
    n = nand2(a, b);
    return nand2(nand2(a, n), nand2(b, n));
  endfunction

  function automatic logic mux2(input logic s, input logic a1, input logic a0);
    return nand2(nand2(s, a1), nand2(inv1(s), a0));
  endfunction

  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] run_val;
  logic [WIDTH-1:0] count_nxt;
  logic             at_bound;
  logic             step_en;
  logic             wrap_nxt;

  // A bit toggles when every lower bit equals up (all ones counting up,
  // all zeros counting down); the carry out of the top bit is the boundary.
  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_bit
    logic c_in;
    logic c_out;
    if (i == 0) begin : g_lsb
      assign c_in = 1'b1;
    end else begin : g_chain
      assign c_in = g_bit[i-1].c_out;
    end
    assign c_out       = and2(c_in, inv1(xor2(count[i], up)));
    assign step_val[i] = xor2(count[i], c_in);
  end

  assign at_bound = g_bit[WIDTH-1].c_out;
  assign tc       = at_bound;
  assign step_en  = and2(en, inv1(load));
  assign wrap_nxt = and2(step_en, at_bound);

  for (i = 0; i < WIDTH; i++) begin : g_sel
    if (SATURATE) begin : g_sat
      assign sat_val[i] = mux2(at_bound, count[i], step_val[i]);
    end else begin : g_wrap
      assign sat_val[i] = step_val[i];
    end
    assign run_val[i]   = mux2(en, sat_val[i], count[i]);
    assign count_nxt[i] = mux2(load, d[i], run_val[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_nand_updown_counter.sv
// tb/tb_nand_updown_counter.sv - scoreboard bench for nand_updown_counter, wrap and saturate builds
module tb_nand_updown_counter;

  typedef struct {
    int         cyc;
    int         dut;
    logic [3:0] cnt;
    logic       wrp;
    string      tag;
  } cw_t;

  typedef struct {
    int    cyc;
    int    dut;
    logic  tcv;
    string tag;
  } tc_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] d = 4'h0;
  logic [3:0] c0, c1;
  logic       t0, t1, w0, w1;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  cw_t q_cw[$];
  tc_t q_tc[$];
  logic [3:0] m0, m1;

  nand_updown_counter #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .count(c0), .tc(t0), .wrap(w0)
  );

  nand_updown_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .count(c1), .tc(t1), .wrap(w1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: count/wrap expectations land one edge after their stimulus,
  // tc expectations are checked in the same cycle the stimulus is applied.
  always @(negedge clk) begin : monitor
    cw_t        a;
    tc_t        b;
    logic [3:0] ac;
    logic       aw, at;
    while (q_cw.size() > 0 && q_cw[0].cyc <= cyc) begin
      a  = q_cw.pop_front();
      ac = (a.dut == 1) ? c1 : c0;
      aw = (a.dut == 1) ? w1 : w0;
      n_cmp++;
      if (ac !== a.cnt) begin
        n_bad++;
        $display("FAIL %s count dut%0d: got %h want %h", a.tag, a.dut, ac, a.cnt);
      end
      n_cmp++;
      if (aw !== a.wrp) begin
        n_bad++;
        $display("FAIL %s wrap dut%0d: got %b want %b", a.tag, a.dut, aw, a.wrp);
      end
    end
    while (q_tc.size() > 0 && q_tc[0].cyc <= cyc) begin
      b  = q_tc.pop_front();
      at = (b.dut == 1) ? t1 : t0;
      n_cmp++;
      if (at !== b.tcv) begin
        n_bad++;
        $display("FAIL %s tc dut%0d: got %b want %b", b.tag, b.dut, at, b.tcv);
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] dv);
    @(posedge clk);
    #2;
    rst = r; en = e; up = u; load = l; d = dv;
  endtask

  task automatic exp_cw(input int dut, input logic [3:0] c, input logic w, input string tag);
    cw_t it;
    it.cyc = cyc + 1; it.dut = dut; it.cnt = c; it.wrp = w; it.tag = tag;
    q_cw.push_back(it);
  endtask

  task automatic exp_tc(input int dut, input logic t, input string tag);
    tc_t it;
    it.cyc = cyc; it.dut = dut; it.tcv = t; it.tag = tag;
    q_tc.push_back(it);
  endtask

  task automatic model_step(input logic sat, inout logic [3:0] m, output logic w);
    w = 1'b0;
    if (rst) m = 4'h0;
    else if (load) m = d;
    else if (en && up) begin
      if (m == 4'hF) begin
        w = 1'b1;
        m = sat ? 4'hF : 4'h0;
      end else m = m + 4'h1;
    end else if (en) begin
      if (m == 4'h0) begin
        w = 1'b1;
        m = sat ? 4'h0 : 4'hF;
      end else m = m - 4'h1;
    end
  endtask

  initial begin
    logic [3:0] e0, e1;
    logic       x0, x1;

    // 1: reset, tc by direction
    drive(1, 0, 1, 0, 4'h0);
    exp_cw(0, 4'h0, 0, "rst1"); exp_cw(1, 4'h0, 0, "rst1");
    drive(1, 0, 1, 0, 4'h0);
    exp_cw(0, 4'h0, 0, "rst2"); exp_cw(1, 4'h0, 0, "rst2");
    exp_tc(0, 0, "rst_up"); exp_tc(1, 0, "rst_up");
    drive(0, 0, 0, 0, 4'h0);
    exp_cw(0, 4'h0, 0, "rst_hold"); exp_cw(1, 4'h0, 0, "rst_hold");
    exp_tc(0, 1, "rst_dn"); exp_tc(1, 1, "rst_dn");

    // 2: count up 16 steps
    for (int i = 1; i <= 16; i++) begin
      drive(0, 1, 1, 0, 4'h0);
      exp_tc(0, (i == 16), "up_tc"); exp_tc(1, (i == 16), "up_tc");
      if (i < 16) begin
        exp_cw(0, 4'(i), 0, "up"); exp_cw(1, 4'(i), 0, "up");
      end else begin
        exp_cw(0, 4'h0, 1, "up_wrap"); exp_cw(1, 4'hF, 1, "up_sat");
      end
    end

    // 3: load 3 with en, count down through 0
    drive(0, 1, 1, 1, 4'h3);
    exp_cw(0, 4'h3, 0, "ld3"); exp_cw(1, 4'h3, 0, "ld3");
    drive(0, 1, 0, 0, 4'h0);
    exp_cw(0, 4'h2, 0, "dn"); exp_cw(1, 4'h2, 0, "dn");
    exp_tc(0, 0, "dn_tc"); exp_tc(1, 0, "dn_tc");
    drive(0, 1, 0, 0, 4'h0);
    exp_cw(0, 4'h1, 0, "dn"); exp_cw(1, 4'h1, 0, "dn");
    drive(0, 1, 0, 0, 4'h0);
    exp_cw(0, 4'h0, 0, "dn"); exp_cw(1, 4'h0, 0, "dn");
    drive(0, 1, 0, 0, 4'h0);
    exp_cw(0, 4'hF, 1, "dn_wrap"); exp_cw(1, 4'h0, 1, "dn_sat");
    exp_tc(0, 1, "dn_tc0"); exp_tc(1, 1, "dn_tc0");

    // 4: saturation at both ends
    drive(0, 1, 1, 1, 4'hE);
    exp_cw(0, 4'hE, 0, "ldE"); exp_cw(1, 4'hE, 0, "ldE");
    drive(0, 1, 1, 0, 4'h0);
    exp_cw(0, 4'hF, 0, "sat_up1"); exp_cw(1, 4'hF, 0, "sat_up1");
    drive(0, 1, 1, 0, 4'h0);
    exp_cw(0, 4'h0, 1, "sat_up2"); exp_cw(1, 4'hF, 1, "sat_up2");
    drive(0, 1, 1, 0, 4'h0);
    exp_cw(0, 4'h1, 0, "sat_up3"); exp_cw(1, 4'hF, 1, "sat_up3");
    drive(0, 0, 0, 1, 4'h1);
    exp_cw(0, 4'h1, 0, "ld1"); exp_cw(1, 4'h1, 0, "ld1");
    drive(0, 1, 0, 0, 4'h0);
    exp_cw(0, 4'h0, 0, "sat_dn1"); exp_cw(1, 4'h0, 0, "sat_dn1");
    drive(0, 1, 0, 0, 4'h0);
    exp_cw(0, 4'hF, 1, "sat_dn2"); exp_cw(1, 4'h0, 1, "sat_dn2");

    // 5: disabled, up toggling; dut0 sits at F, dut1 at 0
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1'(i % 2), 0, 4'h0);
      exp_cw(0, 4'hF, 0, "hold"); exp_cw(1, 4'h0, 0, "hold");
      exp_tc(0, 1'(i % 2), "hold_tc"); exp_tc(1, ~1'(i % 2), "hold_tc");
    end

    // 6: reset beats load
    drive(0, 0, 0, 1, 4'h9);
    exp_cw(0, 4'h9, 0, "ld9"); exp_cw(1, 4'h9, 0, "ld9");
    drive(1, 1, 1, 1, 4'h5);
    exp_cw(0, 4'h0, 0, "rst_vs_ld"); exp_cw(1, 4'h0, 0, "rst_vs_ld");

    // random phase against a behavioural model
    m0 = 4'h0; m1 = 4'h0;
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0), 4'($urandom));
      if (!rst) begin
        exp_tc(0, up ? (m0 == 4'hF) : (m0 == 4'h0), "rnd_tc");
        exp_tc(1, up ? (m1 == 4'hF) : (m1 == 4'h0), "rnd_tc");
      end
      e0 = m0; e1 = m1;
      model_step(1'b0, e0, x0);
      model_step(1'b1, e1, x1);
      m0 = e0; m1 = e1;
      exp_cw(0, m0, x0, "rnd"); exp_cw(1, m1, x1, "rnd");
    end

    drive(0, 0, 0, 0, 4'h0);
    repeat (3) @(posedge clk);
    #6;
    n_cmp++;
    if (q_cw.size() + q_tc.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q_cw.size() + q_tc.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
